// File: rtl/pool_pkg.sv
// Shared helpers for the K x K max-pooling engine: sizing functions, config
// legality check and the signed/unsigned max primitive used by the reduction tree.
package pool_pkg;

    // Widest pixel the reduction tree supports; narrower pixels are extended into it.
    localparam int unsigned MAX_W = 64;

    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int unsigned out_dim(input int unsigned img, input int unsigned k,
                                            input int unsigned s);
        return (img - k) / s + 1;
    endfunction

    function automatic bit cfg_ok(input int unsigned k, input int unsigned s,
                                  input int unsigned img_w, input int unsigned img_h,
                                  input int unsigned dw);
        return (k >= 2) && (k <= 4) && (s >= 1) && (s <= k) &&
               (img_w >= k) && (img_h >= k) && (dw >= 1) && (dw <= MAX_W);
    endfunction

    function automatic logic [MAX_W-1:0] pool_max(input logic [MAX_W-1:0] a,
                                                  input logic [MAX_W-1:0] b,
                                                  input logic is_signed);
        if (is_signed) begin
            return ($signed(a) > $signed(b)) ? a : b;
        end
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/pool_row_buffer.sv
// Single-row delay line: dout is the word written DEPTH enabled cycles earlier.
module pool_row_buffer
    import pool_pkg::*;
#(
    parameter int unsigned DEPTH = 220,
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);
    localparam int unsigned PTR_W = cnt_width(DEPTH);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] ptr;

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= '0;
        end else if (en) begin
            ptr <= (ptr == PTR_LAST) ? '0 : ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (en) begin
            mem[ptr] <= din;
        end
    end

    // Read-before-write at the same slot gives exactly DEPTH accepts of delay.
    assign dout = mem[ptr];

endmodule

// File: rtl/max_pool_kxk.sv
// Streaming K x K / stride S max pooling over a raster pixel stream; one pooled
// value per complete window, two cycles after the completing pixel.
module max_pool_kxk
    import pool_pkg::*;
#(
    parameter int unsigned DATA_WIDHT  = 32,
    parameter int unsigned IMG_WIDHT   = 220,
    parameter int unsigned IMG_HEIGHT  = 220,
    parameter int unsigned POOL_SIZE   = 2,
    parameter int unsigned STRIDE      = 2,
    parameter bit          DATA_SIGNED = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDHT-1:0] Data_In,
    input  logic                  Valid_In,
    output logic [DATA_WIDHT-1:0] Data_Out,
    output logic                  Valid_Out,
    output logic                  Frame_Done
);
    localparam int unsigned K     = POOL_SIZE;
    localparam int unsigned N     = K * K;
    localparam int unsigned OUT_W = out_dim(IMG_WIDHT, K, STRIDE);
    localparam int unsigned OUT_H = out_dim(IMG_HEIGHT, K, STRIDE);
    localparam int unsigned COL_W = cnt_width(IMG_WIDHT);
    localparam int unsigned ROW_W = cnt_width(IMG_HEIGHT);
    localparam int unsigned PH_W  = cnt_width(STRIDE);

    localparam logic [COL_W-1:0] COL_LAST      = COL_W'(IMG_WIDHT - 1);
    localparam logic [COL_W-1:0] COL_FIRST_WIN = COL_W'(K - 1);
    localparam logic [COL_W-1:0] COL_LAST_WIN  = COL_W'(K - 1 + (OUT_W - 1) * STRIDE);
    localparam logic [ROW_W-1:0] ROW_LAST      = ROW_W'(IMG_HEIGHT - 1);
    localparam logic [ROW_W-1:0] ROW_FIRST_WIN = ROW_W'(K - 1);
    localparam logic [ROW_W-1:0] ROW_LAST_WIN  = ROW_W'(K - 1 + (OUT_H - 1) * STRIDE);
    localparam logic [PH_W-1:0]  PH_LAST       = PH_W'(STRIDE - 1);

    if (!cfg_ok(POOL_SIZE, STRIDE, IMG_WIDHT, IMG_HEIGHT, DATA_WIDHT)) begin : g_bad_cfg
        $error("max_pool_kxk: illegal POOL_SIZE/STRIDE/image/data-width configuration");
    end

    logic [COL_W-1:0] col;
    logic [ROW_W-1:0] row;
    logic [PH_W-1:0]  cph;
    logic [PH_W-1:0]  rph;
    logic             col_wrap;
    logic             row_wrap;
    logic             win_done;
    logic             win_last;
    logic             buf_en;

    assign buf_en   = Valid_In && !rst;
    assign col_wrap = (col == COL_LAST);
    assign row_wrap = (row == ROW_LAST);
    assign win_done = Valid_In && (row >= ROW_FIRST_WIN) && (col >= COL_FIRST_WIN) &&
                      (rph == '0) && (cph == '0);
    assign win_last = win_done && (row == ROW_LAST_WIN) && (col == COL_LAST_WIN);

    // Phases start at the first full-window position and restart on every row/frame wrap.
    always_ff @(posedge clk) begin
        if (rst) begin
            col <= '0;
            row <= '0;
            cph <= '0;
            rph <= '0;
        end else if (Valid_In) begin
            if (col_wrap) begin
                col <= '0;
                cph <= '0;
                if (row_wrap) begin
                    row <= '0;
                    rph <= '0;
                end else begin
                    row <= row + 1'b1;
                    if (row >= ROW_FIRST_WIN) begin
                        rph <= (rph == PH_LAST) ? '0 : rph + 1'b1;
                    end
                end
            end else begin
                col <= col + 1'b1;
                if (col >= COL_FIRST_WIN) begin
                    cph <= (cph == PH_LAST) ? '0 : cph + 1'b1;
                end
            end
        end
    end

    // taps[j] is the current column's pixel from j rows above.
    logic [DATA_WIDHT-1:0] taps [K];
    assign taps[0] = Data_In;

    for (genvar j = 1; j < K; j++) begin : g_row_buf
        pool_row_buffer #(
            .DEPTH (IMG_WIDHT),
            .WIDTH (DATA_WIDHT)
        ) u_row_buffer (
            .clk  (clk),
            .rst  (rst),
            .en   (buf_en),
            .din  (taps[j-1]),
            .dout (taps[j])
        );
    end

    // win[r][c]: r = 0 is the oldest row, c = K-1 the newest column.
    logic [DATA_WIDHT-1:0] win [K][K];

    always_ff @(posedge clk) begin
        if (buf_en) begin
            for (int r = 0; r < K; r++) begin
                for (int c = 0; c < K - 1; c++) begin
                    win[r][c] <= win[r][c+1];
                end
                win[r][K-1] <= taps[K-1-r];
            end
        end
    end

    logic win_vld;
    logic win_fd;

    always_ff @(posedge clk) begin
        if (rst) begin
            win_vld <= 1'b0;
            win_fd  <= 1'b0;
        end else begin
            win_vld <= win_done;
            win_fd  <= win_last;
        end
    end

    // Heap-ordered tree: leaves at N-1..2N-2, node i reduces children 2i+1 and 2i+2.
    logic [MAX_W-1:0] node [2*N-1];
    logic [MAX_W-1:0] tree_root;

    always_comb begin
        for (int i = 0; i < 2 * N - 1; i++) begin
            node[i] = '0;
        end
        for (int i = 0; i < N; i++) begin
            if (DATA_SIGNED) begin
                node[N-1+i] = MAX_W'($signed(win[i/K][i%K]));
            end else begin
                node[N-1+i] = MAX_W'(win[i/K][i%K]);
            end
        end
        for (int i = N - 2; i >= 0; i--) begin
            node[i] = pool_max(node[2*i+1], node[2*i+2], DATA_SIGNED);
        end
    end

    assign tree_root = node[0];

    if (DATA_WIDHT < MAX_W) begin : g_root_hi
        logic unused_root_hi;
        assign unused_root_hi = ^tree_root[MAX_W-1:DATA_WIDHT];
    end

    logic [DATA_WIDHT-1:0] tree_q;
    logic                  tree_vld;
    logic                  tree_fd;

    always_ff @(posedge clk) begin
        if (rst) begin
            tree_q     <= '0;
            tree_vld   <= 1'b0;
            tree_fd    <= 1'b0;
            Data_Out   <= '0;
            Valid_Out  <= 1'b0;
            Frame_Done <= 1'b0;
        end else begin
            tree_vld   <= win_vld;
            tree_fd    <= win_fd;
            Valid_Out  <= tree_vld;
            Frame_Done <= tree_fd;
            if (win_vld) begin
                tree_q <= tree_root[DATA_WIDHT-1:0];
            end
            if (tree_vld) begin
                Data_Out <= tree_q;
            end
        end
    end

endmodule

// File: tb/tb_max_pool_kxk.sv
// Bench for max_pool_kxk: several parameterisations driven with directed and random
// frames, checked against a direct window-maximum model with cycle-exact timing.
module tb_max_pool_kxk;

    localparam int ND = 6;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [31:0] din  [ND];
    logic [ND-1:0] vin;
    logic [31:0] dout [ND];
    logic        vout [ND];
    logic        fd   [ND];

    int cfg_w  [ND] = '{4, 5, 2, 2, 7, 10};
    int cfg_h  [ND] = '{4, 5, 2, 2, 6, 9};
    int cfg_k  [ND] = '{2, 3, 2, 2, 3, 4};
    int cfg_s  [ND] = '{2, 2, 2, 2, 1, 3};
    bit cfg_sg [ND] = '{1, 1, 1, 0, 1, 0};

    max_pool_kxk #(.DATA_WIDHT(32), .IMG_WIDHT(4), .IMG_HEIGHT(4), .POOL_SIZE(2), .STRIDE(2),
        .DATA_SIGNED(1'b1)) u_dut0 (.clk(clk), .rst(rst), .Data_In(din[0]), .Valid_In(vin[0]),
        .Data_Out(dout[0]), .Valid_Out(vout[0]), .Frame_Done(fd[0]));
    max_pool_kxk #(.DATA_WIDHT(32), .IMG_WIDHT(5), .IMG_HEIGHT(5), .POOL_SIZE(3), .STRIDE(2),
        .DATA_SIGNED(1'b1)) u_dut1 (.clk(clk), .rst(rst), .Data_In(din[1]), .Valid_In(vin[1]),
        .Data_Out(dout[1]), .Valid_Out(vout[1]), .Frame_Done(fd[1]));
    max_pool_kxk #(.DATA_WIDHT(32), .IMG_WIDHT(2), .IMG_HEIGHT(2), .POOL_SIZE(2), .STRIDE(2),
        .DATA_SIGNED(1'b1)) u_dut2 (.clk(clk), .rst(rst), .Data_In(din[2]), .Valid_In(vin[2]),
        .Data_Out(dout[2]), .Valid_Out(vout[2]), .Frame_Done(fd[2]));
    max_pool_kxk #(.DATA_WIDHT(32), .IMG_WIDHT(2), .IMG_HEIGHT(2), .POOL_SIZE(2), .STRIDE(2),
        .DATA_SIGNED(1'b0)) u_dut3 (.clk(clk), .rst(rst), .Data_In(din[3]), .Valid_In(vin[3]),
        .Data_Out(dout[3]), .Valid_Out(vout[3]), .Frame_Done(fd[3]));
    max_pool_kxk #(.DATA_WIDHT(32), .IMG_WIDHT(7), .IMG_HEIGHT(6), .POOL_SIZE(3), .STRIDE(1),
        .DATA_SIGNED(1'b1)) u_dut4 (.clk(clk), .rst(rst), .Data_In(din[4]), .Valid_In(vin[4]),
        .Data_Out(dout[4]), .Valid_Out(vout[4]), .Frame_Done(fd[4]));
    max_pool_kxk #(.DATA_WIDHT(32), .IMG_WIDHT(10), .IMG_HEIGHT(9), .POOL_SIZE(4), .STRIDE(3),
        .DATA_SIGNED(1'b0)) u_dut5 (.clk(clk), .rst(rst), .Data_In(din[5]), .Valid_In(vin[5]),
        .Data_Out(dout[5]), .Valid_Out(vout[5]), .Frame_Done(fd[5]));

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Output capture, sampled mid-cycle
    logic [31:0] got_d [ND][64];
    int          got_c [ND][64];
    bit          got_f [ND][64];
    int          got_n [ND];
    int          stray [ND];

    always @(negedge clk) begin
        for (int d = 0; d < ND; d++) begin
            if (vout[d] === 1'b1 && got_n[d] < 64) begin
                got_d[d][got_n[d]] = dout[d];
                got_c[d][got_n[d]] = cyc;
                got_f[d][got_n[d]] = fd[d];
                got_n[d]++;
            end else if (fd[d] === 1'b1) begin
                stray[d]++;
            end
        end
    end

    logic [31:0] pix   [256];
    int          stamp [256];
    logic [31:0] exp_d [$];
    int          exp_c [$];
    bit          exp_f [$];

    task automatic clear_all();
        exp_d.delete();
        exp_c.delete();
        exp_f.delete();
        for (int d = 0; d < ND; d++) begin
            got_n[d] = 0;
            stray[d] = 0;
        end
    endtask

    // Leaves Valid_In high after the last pixel so a following frame can abut it.
    task automatic send(input int d, input int n, input int gap_max);
        for (int i = 0; i < n; i++) begin
            int g;
            g = (gap_max > 0) ? int'($urandom_range(gap_max, 0)) : 0;
            repeat (g) begin
                @(negedge clk);
                vin[d] = 1'b0;
                din[d] = $urandom;
            end
            @(negedge clk);
            din[d]   = pix[i];
            vin[d]   = 1'b1;
            stamp[i] = cyc + 1;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            vin = '0;
        end
    endtask

    // Every full KxK window at stride S whose bottom-right pixel is among the first npix.
    task automatic model_frame(input int d, input int npix);
        int w, h, k, s, ow, oh, last;
        logic [31:0] m, v;
        w  = cfg_w[d];
        h  = cfg_h[d];
        k  = cfg_k[d];
        s  = cfg_s[d];
        ow = (w - k) / s + 1;
        oh = (h - k) / s + 1;
        for (int oy = 0; oy < oh; oy++) begin
            for (int ox = 0; ox < ow; ox++) begin
                last = (oy * s + k - 1) * w + ox * s + k - 1;
                if (last < npix) begin
                    m = pix[oy * s * w + ox * s];
                    for (int dy = 0; dy < k; dy++) begin
                        for (int dx = 0; dx < k; dx++) begin
                            v = pix[(oy * s + dy) * w + ox * s + dx];
                            if (cfg_sg[d] ? ($signed(v) > $signed(m)) : (v > m)) m = v;
                        end
                    end
                    exp_d.push_back(m);
                    exp_c.push_back(stamp[last] + 2);
                    exp_f.push_back(oy == oh - 1 && ox == ow - 1);
                end
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        vin[0] = 1'b1;
        din[0] = 32'hDEAD_BEEF;
        @(negedge clk);
        for (int d = 0; d < ND; d++) begin
            tests++;
            if (dout[d] !== 32'h0 || vout[d] !== 1'b0 || fd[d] !== 1'b0) begin
                fails++;
                $display("FAIL reset_state dut%0d: got data=%h valid=%b done=%b, expected 0/0/0",
                         d, dout[d], vout[d], fd[d]);
            end
        end
        rst = 1'b0;
        vin = '0;
    endtask

    task automatic test_k2_stream(input int gap_max);
        clear_all();
        for (int i = 0; i < 16; i++) pix[i] = i;
        send(0, 16, gap_max);
        model_frame(0, 16);
        idle(8);
        tests++;
        if (got_n[0] !== exp_d.size() || stray[0] !== 0) begin
            fails++;
            $display("FAIL k2_gap%0d_count: got %0d outputs (%0d stray done), expected %0d",
                     gap_max, got_n[0], stray[0], exp_d.size());
        end
        for (int i = 0; i < exp_d.size() && i < got_n[0]; i++) begin
            tests++;
            if (got_d[0][i] !== exp_d[i] || got_c[0][i] !== exp_c[i] || got_f[0][i] !== exp_f[i]) begin
                fails++;
                $display("FAIL k2_gap%0d_out%0d: got data=%h cyc=%0d done=%b, expected data=%h cyc=%0d done=%b",
                         gap_max, i, got_d[0][i], got_c[0][i], got_f[0][i], exp_d[i], exp_c[i], exp_f[i]);
            end
        end
        tests++;
        if (vout[0] !== 1'b0 || dout[0] !== exp_d[exp_d.size()-1]) begin
            fails++;
            $display("FAIL k2_gap%0d_hold: got data=%h valid=%b, expected data=%h valid=0",
                     gap_max, dout[0], vout[0], exp_d[exp_d.size()-1]);
        end
    endtask

    task automatic test_k3();
        clear_all();
        for (int i = 0; i < 25; i++) pix[i] = i;
        send(1, 25, 0);
        model_frame(1, 25);
        idle(8);
        tests++;
        if (got_n[1] !== exp_d.size() || stray[1] !== 0) begin
            fails++;
            $display("FAIL k3_count: got %0d outputs (%0d stray done), expected %0d",
                     got_n[1], stray[1], exp_d.size());
        end
        for (int i = 0; i < exp_d.size() && i < got_n[1]; i++) begin
            tests++;
            if (got_d[1][i] !== exp_d[i] || got_c[1][i] !== exp_c[i] || got_f[1][i] !== exp_f[i]) begin
                fails++;
                $display("FAIL k3_out%0d: got data=%h cyc=%0d done=%b, expected data=%h cyc=%0d done=%b",
                         i, got_d[1][i], got_c[1][i], got_f[1][i], exp_d[i], exp_c[i], exp_f[i]);
            end
        end
    endtask

    task automatic test_signedness();
        for (int f = 0; f < 2; f++) begin
            for (int d = 2; d <= 3; d++) begin
                clear_all();
                pix[0] = -5;
                pix[1] = (f == 0) ? -3 : 3;
                pix[2] = -8;
                pix[3] = (f == 0) ? -1 : 1;
                send(d, 4, 0);
                model_frame(d, 4);
                idle(6);
                tests++;
                if (got_n[d] !== 1 || got_d[d][0] !== exp_d[0] || got_c[d][0] !== exp_c[0] ||
                    got_f[d][0] !== 1'b1) begin
                    fails++;
                    $display("FAIL sign_f%0d_dut%0d: got n=%0d data=%h cyc=%0d done=%b, expected n=1 data=%h cyc=%0d done=1",
                             f, d, got_n[d], got_d[d][0], got_c[d][0], got_f[d][0], exp_d[0], exp_c[0]);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        for (int round = 0; round < 2; round++) begin
            int cut;
            cut = (round == 0) ? 6 : 10;
            clear_all();
            for (int i = 0; i < 16; i++) pix[i] = i;
            send(0, cut, 0);
            model_frame(0, cut - (round == 0 ? cut : 0));
            @(negedge clk);
            rst    = 1'b1;
            din[0] = 32'h7FFF_FFFF;
            vin[0] = 1'b1;
            @(negedge clk);
            tests++;
            if (vout[0] !== 1'b0 || dout[0] !== 32'h0) begin
                fails++;
                $display("FAIL rst_mid%0d_state: got data=%h valid=%b, expected 0/0", round, dout[0], vout[0]);
            end
            rst = 1'b0;
            vin = '0;
            idle(2);
            send(0, 16, 0);
            model_frame(0, 16);
            idle(8);
            tests++;
            if (got_n[0] !== exp_d.size() || stray[0] !== 0) begin
                fails++;
                $display("FAIL rst_mid%0d_count: got %0d outputs (%0d stray done), expected %0d",
                         round, got_n[0], stray[0], exp_d.size());
            end
            for (int i = 0; i < exp_d.size() && i < got_n[0]; i++) begin
                tests++;
                if (got_d[0][i] !== exp_d[i] || got_c[0][i] !== exp_c[i] || got_f[0][i] !== exp_f[i]) begin
                    fails++;
                    $display("FAIL rst_mid%0d_out%0d: got data=%h cyc=%0d done=%b, expected data=%h cyc=%0d done=%b",
                             round, i, got_d[0][i], got_c[0][i], got_f[0][i], exp_d[i], exp_c[i], exp_f[i]);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        clear_all();
        for (int i = 0; i < 16; i++) pix[i] = i;
        send(0, 16, 0);
        model_frame(0, 16);
        for (int i = 0; i < 16; i++) pix[i] = 100 + i;
        send(0, 16, 0);
        model_frame(0, 16);
        idle(8);
        tests++;
        if (got_n[0] !== exp_d.size() || stray[0] !== 0) begin
            fails++;
            $display("FAIL b2b_count: got %0d outputs (%0d stray done), expected %0d",
                     got_n[0], stray[0], exp_d.size());
        end
        for (int i = 0; i < exp_d.size() && i < got_n[0]; i++) begin
            tests++;
            if (got_d[0][i] !== exp_d[i] || got_c[0][i] !== exp_c[i] || got_f[0][i] !== exp_f[i]) begin
                fails++;
                $display("FAIL b2b_out%0d: got data=%h cyc=%0d done=%b, expected data=%h cyc=%0d done=%b",
                         i, got_d[0][i], got_c[0][i], got_f[0][i], exp_d[i], exp_c[i], exp_f[i]);
            end
        end
    endtask

    task automatic test_random();
        for (int d = 4; d <= 5; d++) begin
            int npix;
            npix = cfg_w[d] * cfg_h[d];
            clear_all();
            for (int f = 0; f < ((d == 4) ? 2 : 1); f++) begin
                for (int i = 0; i < npix; i++) pix[i] = $urandom;
                send(d, npix, 2);
                model_frame(d, npix);
            end
            idle(10);
            tests++;
            if (got_n[d] !== exp_d.size() || stray[d] !== 0) begin
                fails++;
                $display("FAIL rand_dut%0d_count: got %0d outputs (%0d stray done), expected %0d",
                         d, got_n[d], stray[d], exp_d.size());
            end
            for (int i = 0; i < exp_d.size() && i < got_n[d]; i++) begin
                tests++;
                if (got_d[d][i] !== exp_d[i] || got_c[d][i] !== exp_c[i] || got_f[d][i] !== exp_f[i]) begin
                    fails++;
                    $display("FAIL rand_dut%0d_out%0d: got data=%h cyc=%0d done=%b, expected data=%h cyc=%0d done=%b",
                             d, i, got_d[d][i], got_c[d][i], got_f[d][i], exp_d[i], exp_c[i], exp_f[i]);
                end
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        vin = '0;
        for (int d = 0; d < ND; d++) din[d] = '0;
        test_reset();
        test_k2_stream(0);
        test_k2_stream(3);
        test_k3();
        test_signedness();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
